// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between control/register file and the multiply/divide unit.
// MDU_MTHILO_EN adds the MTHI/MTLO write path (HiWrite, LoWrite, WriteData).
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] RsData;
  logic [DATA_WIDTH-1:0] RtData;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Hi;
  logic [DATA_WIDTH-1:0] Lo;
`ifdef MDU_MTHILO_EN
  logic                  HiWrite;
  logic                  LoWrite;
  logic [DATA_WIDTH-1:0] WriteData;

  modport master (
    output Start, Op, RsData, RtData, HiWrite, LoWrite, WriteData,
    input  Busy, Done, Hi, Lo
  );
  modport slave (
    input  Start, Op, RsData, RtData, HiWrite, LoWrite, WriteData,
    output Busy, Done, Hi, Lo
  );
`else
  modport master (
    output Start, Op, RsData, RtData,
    input  Busy, Done, Hi, Lo
  );
  modport slave (
    input  Start, Op, RsData, RtData,
    output Busy, Done, Hi, Lo
  );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle, HI/LO result pair.
// Optional MTHI/MTLO write path enabled by defining MDU_MTHILO_EN.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_div_unit_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;      // product high half / partial remainder
  logic [W-1:0]   shf_q, shf_d;      // multiplier / dividend shifting into quotient
  logic [W-1:0]   opb_q, opb_d;      // multiplicand / divisor magnitude
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           is_div_q, is_div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           op_signed, op_div, rs_neg, rt_neg;
  logic [W-1:0]   rs_mag, rt_mag, mul_addend, rem_sub, quo_mag, rem_mag;
  logic [W:0]     add_sum, shifted;
  logic           rem_ge;
  logic [2*W-1:0] prod_mag, prod_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shf_d     = shf_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    prod_mag  = '0;
    prod_fix  = '0;
    quo_mag   = '0;
    rem_mag   = '0;

    op_signed  = ~bus.Op[0];
    op_div     = bus.Op[1];
    rs_neg     = op_signed & bus.RsData[W-1];
    rt_neg     = op_signed & bus.RtData[W-1];
    rs_mag     = rs_neg ? -bus.RsData : bus.RsData;
    rt_mag     = rt_neg ? -bus.RtData : bus.RtData;

    mul_addend = shf_q[0] ? opb_q : {W{1'b0}};
    add_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
    shifted    = {acc_q, shf_q[W-1]};
    rem_ge     = shifted >= {1'b0, opb_q};
    // The difference is below the divisor whenever it is kept, so W bits hold it exactly.
    rem_sub    = shifted[W-1:0] - opb_q;

    unique case (state_q)
      S_IDLE: begin
`ifdef MDU_MTHILO_EN
        if (bus.HiWrite) hi_d = bus.WriteData;
        if (bus.LoWrite) lo_d = bus.WriteData;
`endif
        if (bus.Start) begin
          state_d   = S_RUN;
          busy_d    = 1'b1;
          cnt_d     = '0;
          acc_d     = '0;
          shf_d     = op_div ? rs_mag : rt_mag;
          opb_d     = op_div ? rt_mag : rs_mag;
          is_div_d  = op_div;
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          div0_d    = op_div && (bus.RtData == '0);
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = rem_ge ? rem_sub : shifted[W-1:0];
          shf_d = {shf_q[W-2:0], rem_ge};
        end else begin
          acc_d = add_sum[W:1];
          shf_d = {add_sum[0], shf_q[W-1:1]};
        end
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Sign fix-up is applied to the final step's output so HI/LO land on the same edge.
          if (is_div_q) begin
            quo_mag = shf_d;
            rem_mag = acc_d;
            lo_d    = div0_q ? {W{1'b1}} : (neg_res_q ? -quo_mag : quo_mag);
            hi_d    = neg_rem_q ? -rem_mag : rem_mag;
          end else begin
            prod_mag = {acc_d, shf_d};
            prod_fix = neg_res_q ? -prod_mag : prod_mag;
            hi_d     = prod_fix[2*W-1:W];
            lo_d     = prod_fix[W-1:0];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shf_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shf_q     <= shf_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, Busy/Done timing, signed/unsigned results, corner cases.
// Define MDU_MTHILO_EN to also exercise the MTHI/MTLO write path.
module tb_mult_div_unit;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit_if #(.DATA_WIDTH(32)) bus_if ();

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, follow it to completion and check timing and result.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] want_hi, input logic [31:0] want_lo,
                        input bit poke);
    int lat;
    int busy_cnt;
    bus_if.Start  = 1'b1;
    bus_if.Op     = op;
    bus_if.RsData = rs;
    bus_if.RtData = rt;
    @(posedge clk); #1;
    bus_if.Start  = 1'b0;
    bus_if.Op     = ~op;
    bus_if.RsData = $urandom;
    bus_if.RtData = $urandom;
    lat      = 1;
    busy_cnt = 0;
    check_val({name, "_busy_rise"}, {63'd0, bus_if.Busy}, 64'd1);
    while (bus_if.Done !== 1'b1 && lat < 100) begin
      if (bus_if.Busy === 1'b1) busy_cnt++;
      if (lat == 16) begin
        check_val({name, "_hold_hi"}, {32'd0, bus_if.Hi}, {32'd0, exp_hi});
        check_val({name, "_hold_lo"}, {32'd0, bus_if.Lo}, {32'd0, exp_lo});
      end
      bus_if.Start = poke && (lat == 10);
      @(posedge clk); #1;
      lat++;
    end
    bus_if.Start = 1'b0;
    check_val({name, "_done_seen"}, {63'd0, bus_if.Done}, 64'd1);
    check_val({name, "_latency"}, 64'(lat), 64'd33);
    check_val({name, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check_val({name, "_busy_in_done"}, {63'd0, bus_if.Busy}, 64'd0);
    check_val({name, "_hi"}, {32'd0, bus_if.Hi}, {32'd0, want_hi});
    check_val({name, "_lo"}, {32'd0, bus_if.Lo}, {32'd0, want_lo});
    $display("[TB] %s op=%0d rs=0x%08h rt=0x%08h -> hi=0x%08h lo=0x%08h latency=%0d",
             name, op, rs, rt, bus_if.Hi, bus_if.Lo, lat);
    exp_hi = want_hi;
    exp_lo = want_lo;
    if (poke) begin
      bus_if.Start  = 1'b1;
      bus_if.Op     = 2'b01;
      bus_if.RsData = 32'd9;
      bus_if.RtData = 32'd9;
    end
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    check_val({name, "_done_width"}, {63'd0, bus_if.Done}, 64'd0);
    if (poke) check_val({name, "_start_in_done_ignored"}, {63'd0, bus_if.Busy}, 64'd0);
  endtask

  initial begin
    int guard;
    tests_run     = 0;
    tests_failed  = 0;
    exp_hi        = '0;
    exp_lo        = '0;
    rst_n         = 1'b0;
    bus_if.Start  = 1'b0;
    bus_if.Op     = 2'b00;
    bus_if.RsData = '0;
    bus_if.RtData = '0;
`ifdef MDU_MTHILO_EN
    bus_if.HiWrite   = 1'b0;
    bus_if.LoWrite   = 1'b0;
    bus_if.WriteData = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", {63'd0, bus_if.Busy}, 64'd0);
    check_val("reset_done", {63'd0, bus_if.Done}, 64'd0);
    check_val("reset_hi", {32'd0, bus_if.Hi}, 64'd0);
    check_val("reset_lo", {32'd0, bus_if.Lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("idle_no_start", {63'd0, bus_if.Busy}, 64'd0);

    run_op("multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg",    2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_op("div_neg_rs",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_neg_rt",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run_op("divu_by0",    2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0);
    run_op("div_by0_neg", 2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
    run_op("div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("multu_poke",  2'b01, 32'd5,        32'd6,        32'd0,        32'd30,       1'b1);
    run_op("b2b_multu",   2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);

    // Abort mid-operation with an asynchronous reset between clock edges.
    bus_if.Start  = 1'b1;
    bus_if.Op     = 2'b01;
    bus_if.RsData = 32'd3;
    bus_if.RtData = 32'd3;
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", {63'd0, bus_if.Busy}, 64'd0);
    check_val("abort_done", {63'd0, bus_if.Done}, 64'd0);
    check_val("abort_hi", {32'd0, bus_if.Hi}, 64'd0);
    check_val("abort_lo", {32'd0, bus_if.Lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_val("abort_no_commit_hi", {32'd0, bus_if.Hi}, 64'd0);
    check_val("abort_no_commit_lo", {32'd0, bus_if.Lo}, 64'd0);
    check_val("abort_stays_idle", {63'd0, bus_if.Busy}, 64'd0);
    $display("[TB] abort: hi=0x%08h lo=0x%08h busy=%0b", bus_if.Hi, bus_if.Lo, bus_if.Busy);
    exp_hi = '0;
    exp_lo = '0;

`ifdef MDU_MTHILO_EN
    bus_if.HiWrite   = 1'b1;
    bus_if.WriteData = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_if.HiWrite = 1'b0;
    check_val("mthi_idle", {32'd0, bus_if.Hi}, 64'hCAFEF00D);
    $display("[TB] mthi: hi=0x%08h", bus_if.Hi);
    bus_if.Start  = 1'b1;
    bus_if.Op     = 2'b01;
    bus_if.RsData = 32'd2;
    bus_if.RtData = 32'd3;
    @(posedge clk); #1;
    bus_if.Start     = 1'b0;
    bus_if.HiWrite   = 1'b1;
    bus_if.LoWrite   = 1'b1;
    bus_if.WriteData = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    check_val("mthi_in_run_hi", {32'd0, bus_if.Hi}, 64'hCAFEF00D);
    check_val("mtlo_in_run_lo", {32'd0, bus_if.Lo}, 64'd0);
    bus_if.HiWrite = 1'b0;
    bus_if.LoWrite = 1'b0;
    guard = 0;
    while (bus_if.Done !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("mthi_run_done_seen", {63'd0, bus_if.Done}, 64'd1);
    check_val("mthi_run_hi", {32'd0, bus_if.Hi}, 64'd0);
    check_val("mthi_run_lo", {32'd0, bus_if.Lo}, 64'd6);
    $display("[TB] mthi during run: hi=0x%08h lo=0x%08h", bus_if.Hi, bus_if.Lo);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
